// File: rtl/pe_drain_collector.sv
// pe_drain_collector
//   Sink at the tail of a PE result chain. Every valid word from the last PE
//   is captured into a show-ahead FIFO and presented downstream on a
//   ready/valid interface. Each N-th accepted word is tagged as end-of-row.
//   The chain upstream cannot be stalled. When the FIFO is full and nothing
//   leaves in the same cycle, the incoming word is dropped and a sticky
//   overflow flag is set.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   clear      synchronous flush of FIFO, row counter and overflow flag
//   in_data    result word from the last PE (signed, passed through untouched)
//   in_valid   in_data is valid this cycle
//   out_data   head-of-FIFO word, 0 when empty
//   out_valid  FIFO holds at least one word
//   out_ready  downstream accepts the head word this cycle
//   out_last   head word closes a row, 0 when empty
//   level      FIFO occupancy, 0..DEPTH
//   overflow   sticky, a valid input word was dropped
module pe_drain_collector #(
    parameter int D_W_ACC = 32,
    parameter int N       = 4,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [D_W_ACC-1:0]       in_data,
    input  logic                     in_valid,
    output logic [D_W_ACC-1:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Each entry is {row_end, data}; the tag is fixed when the word is written.
    logic [D_W_ACC:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    // Words still to accept before the row closes; the row-end word is the
    // one written while this reaches zero.
    logic [CW-1:0]    wc_rem;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             row_end;
    logic [D_W_ACC:0] head;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign row_end = (wc_rem == '0);

    // A clear cycle swallows both the incoming word and any pop request.
    assign pop  = ~empty & out_ready & ~clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = in_valid & (~full | pop) & ~clear;

    assign head      = mem[rd_ptr];
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : head[D_W_ACC-1:0];
    assign out_last  = ~empty & head[D_W_ACC];

    // Storage carries no reset; stale entries are hidden by the empty gating.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {row_end, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wc_rem   <= CW'(N - 1);
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wc_rem   <= CW'(N - 1);
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                wc_rem <= row_end ? CW'(N - 1) : wc_rem - CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_drain_collector.sv
module tb_pe_drain_collector;

    localparam int D_W_ACC = 32;
    localparam int N       = 4;
    localparam int DEPTH   = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clear = 1'b0;
    logic [D_W_ACC-1:0]  in_data = '0;
    logic                in_valid = 1'b0;
    logic [D_W_ACC-1:0]  out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                out_last;
    logic [4:0]          level;
    logic                overflow;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [D_W_ACC:0] q[$];
    int   mlev     = 0;
    int   mlev_now = 0;
    int   mwc      = 0;
    logic mov      = 1'b0;
    int   pops     = 0;

    pe_drain_collector #(.D_W_ACC(D_W_ACC), .N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compares every handshake against the expected queue.
    always @(negedge clk) begin
        if (rst && !clear) begin
            total++;
            if (out_valid !== (mlev_now != 0))
                $display("FAIL mon_valid: got %b expected %b", out_valid, (mlev_now != 0));
            else
                passed++;
            total++;
            if (level !== 5'(mlev_now))
                $display("FAIL mon_level: got %0d expected %0d", level, mlev_now);
            else
                passed++;
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL mon_extra: got word %h last %b expected no word", out_data, out_last);
                end else begin
                    logic [D_W_ACC:0] exp_w;
                    exp_w = q.pop_front();
                    pops++;
                    if ({out_last, out_data} !== exp_w)
                        $display("FAIL mon_word: got last=%b data=%h expected last=%b data=%h",
                                 out_last, out_data, exp_w[D_W_ACC], exp_w[D_W_ACC-1:0]);
                    else
                        passed++;
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [D_W_ACC-1:0] d, input logic r);
        logic pm;
        logic acc;
        in_valid  = iv;
        in_data   = d;
        out_ready = r;
        mlev_now  = mlev;
        pm  = (mlev > 0) && r;
        acc = iv && ((mlev < DEPTH) || pm);
        if (acc) begin
            q.push_back({(mwc == N - 1), d});
            mwc = (mwc == N - 1) ? 0 : mwc + 1;
        end else if (iv) begin
            mov = 1'b1;
        end
        mlev = mlev + (acc ? 1 : 0) - (pm ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mlev > 0; i++) drive(1'b0, '0, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        mlev = 0;
        mlev_now = 0;
        mwc = 0;
        mov = 1'b0;
    endtask

    // Clear cycle with input valid and pop requested; both must be ignored.
    task automatic do_clear();
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h55;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else passed++;
        total++; if (level !== 5'd0) $display("FAIL rst_level: got %0d expected 0", level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", overflow); else passed++;
        total++; if (out_data !== '0) $display("FAIL rst_data: got %h expected 0", out_data); else passed++;
        in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        drive(1'b1, 32'h11, 1'b0);
        total++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_data !== 32'h11) $display("FAIL first_data: got %h expected 11", out_data); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL first_last: got %b expected 0", out_last); else passed++;
        drain();
    endtask

    task automatic test_row_tagging();
        int p0;
        do_clear();
        p0 = pops;
        for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b1);
        drain();
        total++; if (pops - p0 !== 8) $display("FAIL row_count: got %0d expected 8", pops - p0); else passed++;
    endtask

    task automatic test_fill_overflow();
        int p0;
        do_clear();
        for (int i = 1; i <= 17; i++) drive(1'b1, 32'(i), 1'b0);
        total++; if (level !== 5'd16) $display("FAIL fill_level: got %0d expected 16", level); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL fill_ovf: got %b expected 1", overflow); else passed++;
        total++; if (out_data !== 32'd1) $display("FAIL fill_head: got %h expected 1", out_data); else passed++;
        p0 = pops;
        drain();
        total++; if (pops - p0 !== 16) $display("FAIL fill_drained: got %0d expected 16", pops - p0); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL fill_sticky: got %b expected 1", overflow); else passed++;
    endtask

    task automatic test_full_pop();
        do_clear();
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b1);
            total++; if (level !== 5'd16) $display("FAIL fullpop_level: got %0d expected 16", level); else passed++;
            total++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b expected 0", overflow); else passed++;
        end
        drain();
    endtask

    task automatic test_wrap_negative();
        logic [D_W_ACC-1:0] w;
        int sent;
        logic r;
        do_clear();
        sent = 0;
        for (int c = 0; c < 400 && sent < 40; c++) begin
            r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sent == 5)       w = 32'h8000_0000;
                else if (sent == 20) w = 32'hFFFF_FFFF;
                else if (sent == 30) w = 32'h8000_0001;
                else                 w = $urandom;
                drive(1'b1, w, r);
                sent++;
            end else begin
                drive(1'b0, '0, r);
            end
        end
        total++; if (overflow !== mov) $display("FAIL wrap_ovf: got %b expected %b", overflow, mov); else passed++;
        drain();
        total++; if (q.size() !== 0) $display("FAIL wrap_left: got %0d expected 0", q.size()); else passed++;
    endtask

    task automatic test_clear_reset();
        int p0;
        do_clear();
        for (int i = 0; i < 17; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0);
        for (int i = 0; i < 11; i++) drive(1'b0, '0, 1'b1);
        total++; if (level !== 5'd5) $display("FAIL pre_clear_level: got %0d expected 5", level); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL pre_clear_ovf: got %b expected 1", overflow); else passed++;
        do_clear();
        total++; if (level !== 5'd0) $display("FAIL clear_level: got %0d expected 0", level); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL clear_valid: got %b expected 0", out_valid); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL clear_ovf: got %b expected 0", overflow); else passed++;
        p0 = pops;
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h400 + 32'(i), 1'b1);
        drain();
        total++; if (pops - p0 !== 8) $display("FAIL clear_rows: got %0d expected 8", pops - p0); else passed++;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(i), 1'b0);
        #2 rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL arst_data: got %h expected 0", out_data); else passed++;
        total++; if (level !== 5'd0) $display("FAIL arst_level: got %0d expected 0", level); else passed++;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 32'h77, 1'b0);
        total++; if (out_data !== 32'h77) $display("FAIL arst_after: got %h expected 77", out_data); else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_row_tagging();
        test_fill_overflow();
        test_full_pop();
        test_wrap_negative();
        test_clear_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
